// File: rtl/commit_if.sv
// Head-of-ROB to commit-controller bundle: ROB head fields in, commit/rollback, store,
// redirect and stall strobes out.
interface commit_if #(
    parameter int unsigned ROB_ID_W  = 4,
    parameter int unsigned REG_POS_W = 5,
    parameter int unsigned DATA_W    = 32
);
    logic                 head_valid_in;
    logic                 head_ready_in;
    logic [ROB_ID_W-1:0]  head_rob_id_in;
    logic [1:0]           head_type_in;
    logic [REG_POS_W-1:0] head_rd_in;
    logic [DATA_W-1:0]    head_value_in;
    logic                 head_mispredict_in;
    logic [DATA_W-1:0]    head_target_pc_in;
    logic                 store_done_in;

    logic                 pop_out;
    logic                 commit_sign_out;
    logic [REG_POS_W-1:0] rd_out;
    logic [DATA_W-1:0]    V_out;
    logic [ROB_ID_W-1:0]  Q_out;
    logic                 rollback_sign_out;
    logic                 store_req_out;
    logic                 redirect_valid_out;
    logic [DATA_W-1:0]    redirect_pc_out;
    logic                 stall_dispatch_out;
    logic [31:0]          commit_count_out;

    modport master (
        input  head_valid_in, head_ready_in, head_rob_id_in, head_type_in, head_rd_in,
               head_value_in, head_mispredict_in, head_target_pc_in, store_done_in,
        output pop_out, commit_sign_out, rd_out, V_out, Q_out, rollback_sign_out,
               store_req_out, redirect_valid_out, redirect_pc_out, stall_dispatch_out,
               commit_count_out
    );

    modport slave (
        output head_valid_in, head_ready_in, head_rob_id_in, head_type_in, head_rd_in,
               head_value_in, head_mispredict_in, head_target_pc_in, store_done_in,
        input  pop_out, commit_sign_out, rd_out, V_out, Q_out, rollback_sign_out,
               store_req_out, redirect_valid_out, redirect_pc_out, stall_dispatch_out,
               commit_count_out
    );
endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: commits the ROB head, holds stores until the LSB acks,
// and turns a mispredicted branch into a rollback pulse plus a fixed dispatch stall.
module commit_ctrl #(
    parameter int unsigned ROB_ID_W     = 4,
    parameter int unsigned REG_POS_W    = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic      clk,
    input logic      rst,
    commit_if.master bus
);
    localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {StCommit, StWaitStore, StFlush} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          count_q, count_d;

    logic                 pop, commit_sign, rollback, store_req, redirect, stall;
    logic [REG_POS_W-1:0] rd;
    logic [DATA_W-1:0]    value;
    logic [ROB_ID_W-1:0]  rob_id;
    logic [DATA_W-1:0]    redirect_pc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        commit_sign = 1'b0;
        rollback    = 1'b0;
        store_req   = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        rd          = '0;
        value       = '0;
        rob_id      = '0;
        redirect_pc = '0;
        if (!rst) begin
            unique case (state_q)
                StCommit: begin
                    if (bus.head_valid_in && bus.head_ready_in) begin
                        unique case (bus.head_type_in)
                            2'b01: state_d = StWaitStore;
                            2'b10: begin
                                commit_sign = 1'b1;
                                rd          = bus.head_rd_in;
                                value       = bus.head_value_in;
                                rob_id      = bus.head_rob_id_in;
                                // Rollback empties the ROB, so the branch itself is not popped.
                                if (bus.head_mispredict_in) begin
                                    rollback    = 1'b1;
                                    redirect    = 1'b1;
                                    redirect_pc = bus.head_target_pc_in;
                                    cnt_d       = CNT_W'(FLUSH_CYCLES);
                                    state_d     = StFlush;
                                end else begin
                                    pop = 1'b1;
                                end
                            end
                            default: begin
                                pop         = 1'b1;
                                commit_sign = 1'b1;
                                rd          = bus.head_rd_in;
                                value       = bus.head_value_in;
                                rob_id      = bus.head_rob_id_in;
                            end
                        endcase
                    end
                end
                StWaitStore: begin
                    store_req = 1'b1;
                    if (bus.store_done_in) begin
                        pop     = 1'b1;
                        state_d = StCommit;
                    end
                end
                StFlush: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = StCommit;
                end
                default: state_d = StCommit;
            endcase
        end
    end

    // The mispredict link write retires the branch even though it does not pop.
    assign count_d = count_q + {31'd0, pop | commit_sign};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCommit;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign bus.pop_out            = pop;
    assign bus.commit_sign_out    = commit_sign;
    assign bus.rd_out             = rd;
    assign bus.V_out              = value;
    assign bus.Q_out              = rob_id;
    assign bus.rollback_sign_out  = rollback;
    assign bus.store_req_out      = store_req;
    assign bus.redirect_valid_out = redirect;
    assign bus.redirect_pc_out    = redirect_pc;
    assign bus.stall_dispatch_out = stall;
    assign bus.commit_count_out   = count_q;
endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: retire, store hold, mispredict flush, not-ready head,
// reset during a store wait and counter wrap.
module tb_commit_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    commit_if #(.ROB_ID_W(4), .REG_POS_W(5), .DATA_W(32)) bus ();

    commit_ctrl #(.ROB_ID_W(4), .REG_POS_W(5), .DATA_W(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {pop, commit_sign, rollback, store_req, redirect, stall}
    logic [5:0] strobes;
    assign strobes = {bus.pop_out, bus.commit_sign_out, bus.rollback_sign_out,
                      bus.store_req_out, bus.redirect_valid_out, bus.stall_dispatch_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic head(input logic v, input logic r, input logic [1:0] t, input logic [4:0] rd,
                        input logic [31:0] val, input logic [3:0] q, input logic mis,
                        input logic [31:0] tgt);
        bus.head_valid_in      = v;
        bus.head_ready_in      = r;
        bus.head_type_in       = t;
        bus.head_rd_in         = rd;
        bus.head_value_in      = val;
        bus.head_rob_id_in     = q;
        bus.head_mispredict_in = mis;
        bus.head_target_pc_in  = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        bus.store_done_in = 1'b0;
        head(1'b1, 1'b1, 2'b00, 5'd7, 32'h77, 4'd1, 1'b0, 32'h0);
        step();
        step();
        #1;
        chk("reset_strobes", 32'(strobes), 32'h0);
        chk("reset_rd", 32'(bus.rd_out), 32'h0);
        chk("reset_count", bus.commit_count_out, 32'h0);

        // 1: three back-to-back reg-writes
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            head(1'b1, 1'b1, 2'b00, 5'(i + 1), 32'(32'h11 * (i + 1)), 4'(4 + i), 1'b0, 32'h0);
            #1;
            chk("rw_strobes", 32'(strobes), 32'h30);
            chk("rw_rd", 32'(bus.rd_out), 32'(i + 1));
            chk("rw_V", bus.V_out, 32'(32'h11 * (i + 1)));
            chk("rw_Q", 32'(bus.Q_out), 32'(4 + i));
            step();
        end
        head(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
        #1;
        chk("rw_count", bus.commit_count_out, 32'd3);
        chk("idle_strobes", 32'(strobes), 32'h0);

        // 2: store held until done arrives 4 cycles later
        head(1'b1, 1'b1, 2'b01, 5'd0, 32'h0, 4'd8, 1'b0, 32'h0);
        #1;
        chk("st_commit_cycle", 32'(strobes), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("st_wait", 32'(strobes), 32'h04);
            step();
        end
        bus.store_done_in = 1'b1;
        #1;
        chk("st_done", 32'(strobes), 32'h24);
        step();
        bus.store_done_in = 1'b0;
        head(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
        #1;
        chk("st_after", 32'(strobes), 32'h0);
        chk("st_count", bus.commit_count_out, 32'd4);

        // 3: mispredicted branch -> rollback + redirect, then two stall cycles
        head(1'b1, 1'b1, 2'b10, 5'd1, 32'h1004, 4'd7, 1'b1, 32'h2000);
        #1;
        chk("br_strobes", 32'(strobes), 32'h1A);
        chk("br_rd", 32'(bus.rd_out), 32'd1);
        chk("br_V", bus.V_out, 32'h1004);
        chk("br_Q", 32'(bus.Q_out), 32'd7);
        chk("br_pc", bus.redirect_pc_out, 32'h2000);
        step();
        head(1'b1, 1'b1, 2'b00, 5'd3, 32'h55, 4'd2, 1'b0, 32'h0);
        chk("br_count", bus.commit_count_out, 32'd5);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fl_stall", 32'(strobes), 32'h01);
            chk("fl_rd", 32'(bus.rd_out), 32'h0);
            chk("fl_pc", bus.redirect_pc_out, 32'h0);
            step();
        end
        chk("fl_count", bus.commit_count_out, 32'd5);
        #1;
        chk("fl_resume", 32'(strobes), 32'h30);
        step();
        chk("fl_resume_count", bus.commit_count_out, 32'd6);

        // 4: head valid but not ready for 3 cycles
        head(1'b1, 1'b0, 2'b00, 5'd9, 32'hABC, 4'd3, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nr_strobes", 32'(strobes), 32'h0);
            chk("nr_V", bus.V_out, 32'h0);
            step();
        end
        bus.head_ready_in = 1'b1;
        #1;
        chk("nr_ready", 32'(strobes), 32'h30);
        chk("nr_V_ready", bus.V_out, 32'hABC);
        step();
        chk("nr_count", bus.commit_count_out, 32'd7);

        // 5: reset during WAIT_STORE with store_done high
        head(1'b1, 1'b1, 2'b01, 5'd0, 32'h0, 4'd9, 1'b0, 32'h0);
        step();
        chk("rs_wait", 32'(strobes), 32'h04);
        rst               = 1'b1;
        bus.store_done_in = 1'b1;
        #1;
        chk("rs_in_reset", 32'(strobes), 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("rs_after", 32'(strobes), 32'h0);
        chk("rs_count", bus.commit_count_out, 32'h0);
        bus.store_done_in = 1'b0;
        head(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
        step();

        // 6: retired-instruction counter wraps
        head(1'b1, 1'b1, 2'b00, 5'd4, 32'h44, 4'd1, 1'b0, 32'h0);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        chk("wr_forced", bus.commit_count_out, 32'hFFFF_FFFF);
        release dut.count_q;
        #1;
        chk("wr_strobes", 32'(strobes), 32'h30);
        step();
        chk("wr_count", bus.commit_count_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
